// File: rtl/gen_up_dn_counter.sv
// Synchronous up/down binary counter with registered wrap pulse.
// Optional clamping at the range limits when CNTR_SATURATE_EN is defined.
module gen_up_dn_counter #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  STEP      = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sense,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   sum, diff;

  // The extra top bit of sum/diff is the carry (up) or borrow (down).
  always_comb begin
    data_out_d = data_out_q;
    wrap_d     = 1'b0;
    sum        = {1'b0, data_out_q} + STEP_EXT;
    diff       = {1'b0, data_out_q} - STEP_EXT;
    if (sense) begin
`ifdef CNTR_SATURATE_EN
      if (sum[WIDTH]) begin
        data_out_d = '1;
        wrap_d     = 1'b1;
      end else begin
        data_out_d = sum[WIDTH-1:0];
      end
`else
      data_out_d = sum[WIDTH-1:0];
      wrap_d     = sum[WIDTH];
`endif
    end else begin
`ifdef CNTR_SATURATE_EN
      if (diff[WIDTH]) begin
        data_out_d = '0;
        wrap_d     = 1'b1;
      end else begin
        data_out_d = diff[WIDTH-1:0];
      end
`else
      data_out_d = diff[WIDTH-1:0];
      wrap_d     = diff[WIDTH];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= RESET_VAL;
      wrap_q     <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      wrap_q     <= wrap_d;
    end
  end

  assign data_out = data_out_q;
  assign wrap     = wrap_q;
  assign at_max   = &data_out_q;
  assign at_min   = ~|data_out_q;

endmodule

// File: tb/tb_gen_up_dn_counter.sv
// Self-checking bench for gen_up_dn_counter: a default 32-bit instance and a
// WIDTH=4/STEP=3/RESET_VAL=13 instance, each checked against an arithmetic model.
module tb_gen_up_dn_counter;

  logic        clk = 1'b0;
  logic        reset_a, sense_a, reset_b, sense_b;
  logic [31:0] dout_a;
  logic [3:0]  dout_b;
  logic        max_a, min_a, wrap_a, max_b, min_b, wrap_b;

  int checks = 0;
  int errors = 0;

  longint m_a, m_b;
  bit     mw_a, mw_b;

  always #5 clk = ~clk;

  gen_up_dn_counter dut_a (
    .clk(clk), .reset(reset_a), .sense(sense_a),
    .data_out(dout_a), .at_max(max_a), .at_min(min_a), .wrap(wrap_a)
  );

  gen_up_dn_counter #(.WIDTH(4), .STEP(4'd3), .RESET_VAL(4'd13)) dut_b (
    .clk(clk), .reset(reset_b), .sense(sense_b),
    .data_out(dout_b), .at_max(max_b), .at_min(min_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next count from the plain-integer value; out-of-range is detected by
  // comparing against the representable range, then clamped or reduced mod 2^w.
  function automatic void nxt(input longint cur, input bit rst, input bit up,
                              input int w, input longint step, input longint rv,
                              output longint n, output bit wr);
    longint mx, v;
    mx = (longint'(1) << w) - 1;
    if (rst) begin
      n  = rv;
      wr = 1'b0;
      return;
    end
    v  = up ? cur + step : cur - step;
    wr = (v > mx) || (v < 0);
`ifdef CNTR_SATURATE_EN
    n = (v > mx) ? mx : (v < 0) ? 0 : v;
`else
    n = v & mx;
`endif
  endfunction

  task automatic tick();
    longint n;
    bit     w;
    nxt(m_a, reset_a, sense_a === 1'b1, 32, 1, 0, n, w);
    m_a = n; mw_a = w;
    nxt(m_b, reset_b, sense_b === 1'b1, 4, 3, 13, n, w);
    m_b = n; mw_b = w;
    @(posedge clk);
    #1;
    chk("a_data", {32'b0, dout_a}, m_a);
    chk("a_wrap", {63'b0, wrap_a}, {63'b0, mw_a});
    chk("a_max",  {63'b0, max_a},  {63'b0, m_a == 64'hFFFF_FFFF});
    chk("a_min",  {63'b0, min_a},  {63'b0, m_a == 0});
    chk("b_data", {60'b0, dout_b}, m_b);
    chk("b_wrap", {63'b0, wrap_b}, {63'b0, mw_b});
    chk("b_max",  {63'b0, max_b},  {63'b0, m_b == 15});
    chk("b_min",  {63'b0, min_b},  {63'b0, m_b == 0});
  endtask

  initial begin
    m_a = 0; m_b = 0; mw_a = 0; mw_b = 0;
    #2;
    // Reset with sense unknown: must be ignored
    reset_a = 1'b1; sense_a = 1'bx;
    reset_b = 1'b1; sense_b = 1'bx;
    tick(); tick();
    chk("tp_reset_a", {32'b0, dout_a}, 64'd0);
    chk("tp_reset_b", {60'b0, dout_b}, 64'd13);

    // Release counting up
    reset_a = 1'b0; sense_a = 1'b1;
    reset_b = 1'b0; sense_b = 1'b1;
    repeat (5) tick();
    chk("tp_up5", {32'b0, dout_a}, 64'd5);

    // Count down across zero
    sense_a = 1'b0;
    repeat (7) tick();
`ifdef CNTR_SATURATE_EN
    chk("tp_down7", {32'b0, dout_a}, 64'd0);
`else
    chk("tp_down7", {32'b0, dout_a}, 64'hFFFF_FFFE);
`endif

    // Reset mid-count at 0x20, then release counting down
    reset_a = 1'b1; tick();
    reset_a = 1'b0; sense_a = 1'b1;
    repeat (32) tick();
    chk("tp_at20", {32'b0, dout_a}, 64'h20);
    reset_a = 1'b1; tick();
    chk("tp_midreset", {32'b0, dout_a}, 64'd0);
    reset_a = 1'b0; sense_a = 1'b0; tick();
`ifdef CNTR_SATURATE_EN
    chk("tp_rel_down", {32'b0, dout_a}, 64'd0);
`else
    chk("tp_rel_down", {32'b0, dout_a}, 64'hFFFF_FFFF);
`endif

    // Toggle direction every edge starting from 10
    reset_a = 1'b1; tick();
    reset_a = 1'b0; sense_a = 1'b1;
    repeat (10) tick();
    for (int unsigned i = 0; i < 4; i++) begin
      sense_a = (i % 2 == 0);
      sense_b = (i % 2 == 0);
      tick();
    end
    chk("tp_toggle", {32'b0, dout_a}, 64'd10);

    // Randomized directions with occasional resets
    for (int unsigned i = 0; i < 400; i++) begin
      sense_a = 1'($urandom);
      sense_b = 1'($urandom);
      reset_a = ($urandom_range(0, 24) == 0);
      reset_b = ($urandom_range(0, 24) == 0);
      tick();
    end

    // Long runs in one direction to hit the limits repeatedly
    reset_a = 1'b0; reset_b = 1'b0;
    sense_b = 1'b1; repeat (12) tick();
    sense_b = 1'b0; repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
